pset_calc_pipe: RTL and testbench
=================================

PSET_CALC_PIPE -- requirements
Module: pset_calc_pipe

Interface
REQ-001 Parameter AW, default 8: width of operand a.
REQ-002 Parameter BW, default 16: width of operands b1, b2.
REQ-003 Parameter NCH, default 4: number of compare channels, minimum 2.
REQ-004 Parameter CW, default 2: width of each channel value.
REQ-005 Parameter SIGNED_INPUT, default 0: 1 = b1/b2 two's complement, 0 = unsigned.
REQ-006 Parameter MATCH_VAL, default 1: channel value searched for; must fit in CW bits.
REQ-007 Port clk, input, 1: sole clock, rising edge.
REQ-008 Port reset, input, 1: synchronous, active-high.
REQ-009 Port in_valid, input, 1: input beat offered.
REQ-010 Port in_ready, output, 1: block accepts the beat this cycle.
REQ-011 Port a, input, AW: popcount operand.
REQ-012 Port b1, input, BW: addend 1.
REQ-013 Port b2, input, BW: addend 2.
REQ-014 Port ch, input, NCH*CW: channel i at bits [i*CW +: CW].
REQ-015 Port clr_total, input, 1: clear match_total.
REQ-016 Port out_valid, output, 1: result beat present.
REQ-017 Port out_ready, input, 1: downstream accepts the result.
REQ-018 Port popcnt, output, clog2(AW+1): number of ones in a.
REQ-019 Port sum, output, BW+1: b1+b2, full precision.
REQ-020 Port match_found, output, 1: at least one channel equals MATCH_VAL.
REQ-021 Port match_idx, output, max(1,clog2(NCH)): lowest matching channel index; 0 when none.
REQ-022 Port match_all, output, 1: every channel equals MATCH_VAL.
REQ-023 Port match_total, output, 16: count of delivered beats with match_found=1.

Function
REQ-024 A beat is accepted when in_valid && in_ready; a result is delivered when out_valid && out_ready.
REQ-025 Two-stage pipeline: stage 1 registers the operands; stage 2 registers the computed results.
REQ-026 Latency is exactly 2 cycles from acceptance to out_valid when there is no backpressure; throughput is 1 beat/cycle.
REQ-027 in_ready = !s1_valid || s2 can accept (s2 can accept = !out_valid || out_ready).
REQ-028 in_ready shall not depend combinationally on in_valid.
REQ-029 While out_valid && !out_ready, all result outputs shall hold stable and no beat shall be lost or duplicated.
REQ-030 Results shall be delivered in acceptance order.
REQ-031 sum: SIGNED_INPUT=1 sign-extends b1 and b2 to BW+1 bits before adding; SIGNED_INPUT=0 zero-extends them. No overflow is possible.
REQ-032 match_idx is a priority encode with channel 0 highest priority; match_all=1 implies match_found=1.
REQ-033 match_total increments by 1 on each delivered beat with match_found=1 and saturates at 16'hFFFF.
REQ-034 clr_total zeroes match_total and takes priority over a simultaneous increment.
REQ-035 Input data not accepted shall be ignored.

Reset
REQ-036 reset sets s1_valid=0, out_valid=0, match_total=0, and popcnt, sum, match_found, match_idx and match_all to 0.
REQ-037 Reset mid-operation discards all in-flight beats; in_ready=1 in the first cycle after reset deasserts.

Structure
REQ-038 Package pset_pkg holds the clog2-based width helper functions and the MATCH_VAL default constant.
REQ-039 A single sub-module, pset_prio_enc, performs the NCH-way compare and priority encode.

Verification
REQ-040 Defaults: a=8'd16, b1=5, b2=127, ch={1,1,1,1} -> popcnt=1, sum=132, match_idx=0, match_all=1, out_valid exactly 2 cycles after acceptance.
REQ-041 a=8'hA7, b1=456, b2=123, ch0..3={1,3,3,3}: MATCH_VAL=1 -> popcnt=5, sum=579, idx=0, all=0; MATCH_VAL=3 -> idx=1, all=0.
REQ-042 ch0..3={0,0,0,0} with MATCH_VAL=1 -> match_found=0, match_idx=0, match_total unchanged.
REQ-043 b1=16'hFFFF, b2=16'h0001: SIGNED_INPUT=0 -> sum=17'h10000; SIGNED_INPUT=1 -> sum=17'h00000.
REQ-044 10 back-to-back beats with out_ready toggled randomly -> all 10 results arrive in order, none lost or duplicated, outputs stable while stalled.
REQ-045 match_total preset to 16'hFFFF plus one matching delivery -> stays 16'hFFFF; clr_total coincident with a matching delivery -> 0; reset with 2 beats in flight -> out_valid=0 next cycle.

Source files
------------

// File: rtl/pset_pkg.sv
// Shared width helpers and defaults for the pset calc pipeline.
package pset_pkg;

  localparam int unsigned MATCH_VAL_DEFAULT = 1;

  // Bits needed to hold a count in the range 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Bits needed to index n items, never less than one.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pset_prio_enc.sv
// NCH-way compare of channel values against MATCH_VAL with a lowest-index priority encode.
module pset_prio_enc #(
  parameter int unsigned NCH       = 4,
  parameter int unsigned CW        = 2,
  parameter int unsigned MATCH_VAL = 1,
  parameter int unsigned IW        = 2
) (
  input  logic [NCH*CW-1:0] ch,
  output logic              found,
  output logic [IW-1:0]     idx,
  output logic              all_match
);

  logic [NCH-1:0] hit;

  always_comb begin
    hit = '0;
    for (int i = 0; i < NCH; i++) begin
      hit[i] = (ch[i*CW +: CW] == CW'(MATCH_VAL));
    end
  end

  // Scan from the top so the lowest matching channel wins.
  always_comb begin
    idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (hit[i]) begin
        idx = IW'(i);
      end
    end
  end

  assign found     = |hit;
  assign all_match = &hit;

endmodule

// File: rtl/pset_calc_pipe.sv
// Two-stage valid/ready pipeline computing popcount, full-precision sum and channel match results.
module pset_calc_pipe
  import pset_pkg::*;
#(
  parameter int unsigned AW           = 8,
  parameter int unsigned BW           = 16,
  parameter int unsigned NCH          = 4,
  parameter int unsigned CW           = 2,
  parameter bit          SIGNED_INPUT = 1'b0,
  parameter int unsigned MATCH_VAL    = MATCH_VAL_DEFAULT,
  localparam int unsigned PW          = cnt_width(AW),
  localparam int unsigned IW          = idx_width(NCH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AW-1:0]     a,
  input  logic [BW-1:0]     b1,
  input  logic [BW-1:0]     b2,
  input  logic [NCH*CW-1:0] ch,
  input  logic              clr_total,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PW-1:0]     popcnt,
  output logic [BW:0]       sum,
  output logic              match_found,
  output logic [IW-1:0]     match_idx,
  output logic              match_all,
  output logic [15:0]       match_total
);

  logic              s1_valid;
  logic [AW-1:0]     s1_a;
  logic [BW-1:0]     s1_b1;
  logic [BW-1:0]     s1_b2;
  logic [NCH*CW-1:0] s1_ch;

  logic              s2_ready;
  logic              accept;
  logic              deliver;

  logic [PW-1:0]     pop_d;
  logic [BW:0]       b1_ext;
  logic [BW:0]       b2_ext;
  logic [BW:0]       sum_d;
  logic              found_d;
  logic [IW-1:0]     idx_d;
  logic              all_d;

  // Stage 2 frees up when it is empty or its result is being taken this cycle.
  assign s2_ready = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_ready;
  assign accept   = in_valid && in_ready;
  assign deliver  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_a  <= a;
      s1_b1 <= b1;
      s1_b2 <= b2;
      s1_ch <= ch;
    end
  end

  always_comb begin
    pop_d = '0;
    for (int i = 0; i < AW; i++) begin
      pop_d = pop_d + PW'(s1_a[i]);
    end
  end

  always_comb begin
    b1_ext = SIGNED_INPUT ? {s1_b1[BW-1], s1_b1} : {1'b0, s1_b1};
    b2_ext = SIGNED_INPUT ? {s1_b2[BW-1], s1_b2} : {1'b0, s1_b2};
    sum_d  = b1_ext + b2_ext;
  end

  pset_prio_enc #(
    .NCH       (NCH),
    .CW        (CW),
    .MATCH_VAL (MATCH_VAL),
    .IW        (IW)
  ) u_prio_enc (
    .ch        (s1_ch),
    .found     (found_d),
    .idx       (idx_d),
    .all_match (all_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      popcnt      <= '0;
      sum         <= '0;
      match_found <= 1'b0;
      match_idx   <= '0;
      match_all   <= 1'b0;
    end else if (s2_ready) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        popcnt      <= pop_d;
        sum         <= sum_d;
        match_found <= found_d;
        match_idx   <= idx_d;
        match_all   <= all_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr_total) begin
      match_total <= '0;
    end else if (deliver && match_found && (match_total != 16'hFFFF)) begin
      match_total <= match_total + 16'd1;
    end
  end

endmodule

// File: tb/tb_pset_calc_pipe.sv
// Scoreboard bench for pset_calc_pipe: an unsigned/MATCH_VAL=1 and a signed/MATCH_VAL=3 instance.
module tb_pset_calc_pipe;

  typedef struct packed {
    logic [3:0]  popcnt;
    logic [16:0] sum0;
    logic [16:0] sum1;
    logic        found0;
    logic [1:0]  idx0;
    logic        all0;
    logic        found1;
    logic [1:0]  idx1;
    logic        all1;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  a = '0;
  logic [15:0] b1 = '0;
  logic [15:0] b2 = '0;
  logic [7:0]  ch = '0;
  logic        clr_total = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, match_found, match_all;
  logic [3:0]  popcnt;
  logic [16:0] sum;
  logic [1:0]  match_idx;
  logic [15:0] match_total;

  logic        in_ready1, out_valid1, match_found1, match_all1;
  logic [3:0]  popcnt1;
  logic [16:0] sum1;
  logic [1:0]  match_idx1;
  logic [15:0] match_total1;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  exp_t        sb[$];
  logic [15:0] mt0 = '0;
  logic [15:0] mt1 = '0;
  bit          mon_on = 1'b0;

  always #5 clk = ~clk;

  pset_calc_pipe dut0 (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b1          (b1),
    .b2          (b2),
    .ch          (ch),
    .clr_total   (clr_total),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .popcnt      (popcnt),
    .sum         (sum),
    .match_found (match_found),
    .match_idx   (match_idx),
    .match_all   (match_all),
    .match_total (match_total)
  );

  pset_calc_pipe #(
    .SIGNED_INPUT (1'b1),
    .MATCH_VAL    (3)
  ) dut1 (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready1),
    .a           (a),
    .b1          (b1),
    .b2          (b2),
    .ch          (ch),
    .clr_total   (clr_total),
    .out_valid   (out_valid1),
    .out_ready   (out_ready),
    .popcnt      (popcnt1),
    .sum         (sum1),
    .match_found (match_found1),
    .match_idx   (match_idx1),
    .match_all   (match_all1),
    .match_total (match_total1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [7:0] ma, input logic [15:0] mb1,
                                 input logic [15:0] mb2, input logic [7:0] mch);
    exp_t e;
    logic [1:0] v;
    e = '0;
    e.popcnt = 4'($countones(ma));
    e.sum0   = {1'b0, mb1} + {1'b0, mb2};
    e.sum1   = {mb1[15], mb1} + {mb2[15], mb2};
    e.all0   = 1'b1;
    e.all1   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      v = mch[2*i +: 2];
      if (v == 2'd1) begin
        if (!e.found0) e.idx0 = 2'(i);
        e.found0 = 1'b1;
      end else begin
        e.all0 = 1'b0;
      end
      if (v == 2'd3) begin
        if (!e.found1) e.idx1 = 2'(i);
        e.found1 = 1'b1;
      end else begin
        e.all1 = 1'b0;
      end
    end
    return e;
  endfunction

  // Monitor: outputs are sampled mid-cycle; inputs only change just after the rising edge.
  always @(negedge clk) begin
    if (mon_on) begin
      check("total0", match_total, mt0);
      check("total1", match_total1, mt1);
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("sb_empty", sb.size(), 1);
        end else begin
          check("popcnt", popcnt, sb[0].popcnt);
          check("sum0", sum, sb[0].sum0);
          check("found0", match_found, sb[0].found0);
          check("idx0", match_idx, sb[0].idx0);
          check("all0", match_all, sb[0].all0);
          check("valid1", out_valid1, 1'b1);
          check("popcnt1", popcnt1, sb[0].popcnt);
          check("sum1", sum1, sb[0].sum1);
          check("found1", match_found1, sb[0].found1);
          check("idx1", match_idx1, sb[0].idx1);
          check("all1", match_all1, sb[0].all1);
        end
      end
      if (reset) begin
        mt0 = '0;
        mt1 = '0;
        sb.delete();
      end else begin
        if (clr_total) begin
          mt0 = '0;
          mt1 = '0;
        end else if (out_valid && out_ready && sb.size() > 0) begin
          if (sb[0].found0 && mt0 != 16'hFFFF) mt0 = mt0 + 16'd1;
          if (sb[0].found1 && mt1 != 16'hFFFF) mt1 = mt1 + 16'd1;
        end
        if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
        if (in_valid && in_ready) sb.push_back(model(a, b1, b2, ch));
      end
    end
  end

  // Drive one beat into an idle pipeline and return at the negedge where out_valid rises.
  task automatic send_one(input logic [7:0] ta, input logic [15:0] tb1, input logic [15:0] tb2,
                          input logic [7:0] tch, output int lat);
    a = ta;
    b1 = tb1;
    b2 = tb2;
    ch = tch;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("idle_ready", in_ready, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
    check("drained", sb.size(), 0);
    #1;
  endtask

  initial begin
    int lat;
    bit acc;
    int tries;

    repeat (2) @(posedge clk);
    #1 mon_on = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_valid", out_valid, 1'b0);
    check("rst_popcnt", popcnt, 0);
    check("rst_sum", sum, 0);
    check("rst_found", match_found, 1'b0);
    check("rst_idx", match_idx, 0);
    check("rst_all", match_all, 1'b0);
    check("rst_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Default pattern: every channel equals 1.
    send_one(8'd16, 16'd5, 16'd127, 8'h55, lat);
    check("lat", lat, 2);
    check("d_popcnt", popcnt, 1);
    check("d_sum", sum, 132);
    check("d_idx", match_idx, 0);
    check("d_all", match_all, 1'b1);

    // ch0..3 = {1,3,3,3}
    send_one(8'hA7, 16'd456, 16'd123, 8'hFD, lat);
    check("p_popcnt", popcnt, 5);
    check("p_sum", sum, 579);
    check("p_idx0", match_idx, 0);
    check("p_all0", match_all, 1'b0);
    check("p_idx1", match_idx1, 1);
    check("p_all1", match_all1, 1'b0);

    send_one(8'h00, 16'd1, 16'd2, 8'h00, lat);
    check("z_found", match_found, 1'b0);
    check("z_idx", match_idx, 0);

    send_one(8'hFF, 16'hFFFF, 16'h0001, 8'hC0, lat);
    check("ov_sum_u", sum, 17'h10000);
    check("ov_sum_s", sum1, 17'h00000);
    check("ov_popcnt", popcnt, 8);
    check("ov_idx1", match_idx1, 3);

    // Back-to-back beats under random backpressure.
    for (int i = 0; i < 10; i++) begin
      a = 8'($urandom);
      b1 = 16'($urandom);
      b2 = 16'($urandom);
      ch = 8'($urandom);
      in_valid = 1'b1;
      out_ready = 1'($urandom);
      tries = 0;
      do begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1 out_ready = 1'($urandom);
        tries++;
      end while (!acc && tries < 50);
      if (!acc) check("accept_timeout", tries, 0);
    end
    in_valid = 1'b0;
    drain();

    // Clear coincident with a matching delivery.
    a = 8'h01;
    b1 = 16'd1;
    b2 = 16'd1;
    ch = 8'h07;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("clr_pre_valid", out_valid, 1'b1);
    @(posedge clk);
    #1;
    clr_total = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 clr_total = 1'b0;
    @(negedge clk);
    check("clr_total0", match_total, 0);
    check("clr_total1", match_total1, 0);
    @(posedge clk);
    #1;

    // Saturation: stream more matching beats than the counter can hold.
    ch = 8'h07;
    in_valid = 1'b1;
    out_ready = 1'b1;
    repeat (65540) @(posedge clk);
    #1 in_valid = 1'b0;
    drain();
    @(negedge clk);
    check("sat_total0", match_total, 16'hFFFF);
    check("sat_total1", match_total1, 16'hFFFF);
    @(posedge clk);
    #1;

    // Reset with two beats in flight.
    out_ready = 1'b0;
    a = 8'h0F;
    b1 = 16'd9;
    b2 = 16'd9;
    ch = 8'h55;
    in_valid = 1'b1;
    @(posedge clk);
    #1 a = 8'hF0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rr_valid", out_valid, 1'b0);
    check("rr_ready", in_ready, 1'b1);
    check("rr_sum", sum, 0);
    check("rr_total", match_total, 0);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rr_flushed", out_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
